// File: rtl/message_scroll_source_pkg.sv
// -----------------------------------------------------------------------------
// message_scroll_source_pkg
// Shared definitions for the scrolling-message character source:
//   - 2-bit letter codes understood by the per-digit displayer decoders
//   - controller state encoding
//   - clog2 helper for sizing counters and pointers from parameters
// -----------------------------------------------------------------------------
package message_scroll_source_pkg;

    localparam logic [1:0] CODE_D     = 2'b00;
    localparam logic [1:0] CODE_E     = 2'b01;
    localparam logic [1:0] CODE_ONE   = 2'b10;
    localparam logic [1:0] CODE_BLANK = 2'b11;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Number of bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/message_scroll_source_key_press_detect.sv
// -----------------------------------------------------------------------------
// key_press_detect
// Turns a raw active-low push-button into a single-cycle press pulse.
// The button is brought into the clk domain with a 2-flop synchroniser; a
// registered falling-edge detector then emits one pulse per press, so a held
// key produces exactly one event. The pulse is high in the cycle after the
// third clk edge following the key going low.
//
// Ports:
//   clk    in   system clock
//   aclr   in   asynchronous active-low reset (flops preset to "released")
//   key_n  in   raw push-button, active-low, asynchronous to clk
//   press  out  one-cycle pulse on each synchronised 1->0 transition
// -----------------------------------------------------------------------------
module key_press_detect (
    input  logic clk,
    input  logic aclr,
    input  logic key_n,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic press_q;
    logic press_d;

    // Falling edge of the synchronised key level.
    assign press_d = prev_q & ~sync2_q;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/message_scroll_source.sv
// -----------------------------------------------------------------------------
// message_scroll_source
// Character source for the six-digit seven-segment word display. A circular
// message of MSG_LEN letter codes is entered one character per key press in
// LOAD mode; in RUN mode a 6-character window rotates over the message once
// every TICK clock cycles. HOLD freezes the scroll while pause is high.
//
// Ports:
//   clk        in   system clock
//   aclr       in   asynchronous active-low reset
//   code_in    in   letter code to write (00=d, 01=E, 10=1, 11=blank)
//   wr_key     in   raw push-button, active-low, asynchronous
//   mode       in   0 = load, 1 = run
//   dir        in   0 = scroll left (base+1), 1 = scroll right (base-1)
//   pause      in   1 = freeze scrolling while running
//   c0..c5     out  window characters, c0 = leftmost digit (HEX5)
//   wr_ptr     out  next message slot to be written
//   running    out  high in RUN only
//   tick       out  one-cycle pulse on each scroll step
// -----------------------------------------------------------------------------
module message_scroll_source
    import message_scroll_source_pkg::*;
#(
    parameter int TICK    = 50000000,
    parameter int MSG_LEN = 8
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic [1:0]                code_in,
    input  logic                      wr_key,
    input  logic                      mode,
    input  logic                      dir,
    input  logic                      pause,
    output logic [1:0]                c0,
    output logic [1:0]                c1,
    output logic [1:0]                c2,
    output logic [1:0]                c3,
    output logic [1:0]                c4,
    output logic [1:0]                c5,
    output logic [clog2(MSG_LEN)-1:0] wr_ptr,
    output logic                      running,
    output logic                      tick
);

    localparam int PW = clog2(MSG_LEN);
    localparam int TW = clog2(TICK);

    localparam logic [PW-1:0] LAST_SLOT  = PW'(MSG_LEN - 1);
    localparam logic [PW:0]   MSG_LEN_W  = (PW + 1)'(MSG_LEN);
    localparam logic [TW-1:0] PRESC_LAST = TW'(TICK - 1);

    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] base_q;
    logic [PW-1:0] base_d;
    logic [TW-1:0] presc_q;
    logic [TW-1:0] presc_d;
    logic [1:0]    mem_q [MSG_LEN];
    logic          wr_en;
    logic          press;
    logic          step;
    logic [1:0]    win [6];

    function automatic logic [PW-1:0] slot_inc(input logic [PW-1:0] s);
        return (s == LAST_SLOT) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [PW-1:0] slot_dec(input logic [PW-1:0] s);
        return (s == '0) ? LAST_SLOT : s - 1'b1;
    endfunction

    key_press_detect u_key (
        .clk   (clk),
        .aclr  (aclr),
        .key_n (wr_key),
        .press (press)
    );

    // A step is tied to the RUN state only; HOLD never steps.
    assign step = (state_q == RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        base_d   = base_q;
        presc_d  = presc_q;
        wr_en    = 1'b0;

        case (state_q)
            LOAD: begin
                if (press) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = slot_inc(wr_ptr_q);
                end
                if (mode) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end

            RUN: begin
                // A step due on this edge always happens, even when the same
                // edge leaves RUN; pause freezes the count only off-step.
                if (step) begin
                    presc_d = '0;
                    base_d  = dir ? slot_dec(base_q) : slot_inc(base_q);
                end else if (!pause) begin
                    presc_d = presc_q + 1'b1;
                end
                if (!mode) begin
                    state_d  = LOAD;
                    base_d   = '0;
                    wr_ptr_d = '0;
                    presc_d  = '0;
                end else if (pause) begin
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (!mode) begin
                    state_d  = LOAD;
                    base_d   = '0;
                    wr_ptr_d = '0;
                    presc_d  = '0;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d  = LOAD;
                base_d   = '0;
                wr_ptr_d = '0;
                presc_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            base_q   <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            base_q   <= base_d;
            presc_q  <= presc_d;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= CODE_BLANK;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= code_in;
        end
    end

    // base+k never exceeds 2*MSG_LEN-1 because MSG_LEN >= 6, so a single
    // compare-and-subtract gives the modulo.
    always_comb begin
        logic [PW:0] idx;
        idx = '0;
        win = '{default: CODE_BLANK};
        for (int k = 0; k < 6; k++) begin
            idx = {1'b0, base_q} + (PW + 1)'(k);
            if (idx >= MSG_LEN_W) begin
                idx = idx - MSG_LEN_W;
            end
            win[k] = mem_q[idx[PW-1:0]];
        end
    end

    assign c0      = win[0];
    assign c1      = win[1];
    assign c2      = win[2];
    assign c3      = win[3];
    assign c4      = win[4];
    assign c5      = win[5];
    assign wr_ptr  = wr_ptr_q;
    assign running = (state_q == RUN);
    assign tick    = step;

endmodule

// File: doc/message_scroll_source.md
Name: message_scroll_source

Overview:
- Upstream character source for the six-digit seven-segment word display.
- Stores a user-entered circular message of MSG_LEN 2-bit letter codes, entered one at a time from switches with a key press.
- In run mode it rotates a 6-character window over the message once per TICK clock cycles.
- Outputs c0..c5 drive the existing per-digit 2-bit displayer decoders directly. c0 is the leftmost digit (HEX5).

Parameters:
- TICK, 50000000: clk cycles per scroll step; legal range is 2 or more.
- MSG_LEN, 8: message length in characters; legal range is 6 or more. A window position wraps modulo MSG_LEN.

Ports:
- clk  in  1  system clock (50 MHz)
- aclr  in  1  asynchronous active-low reset
- code_in  in  2  letter code to write: 00=d, 01=E, 10=1, 11=blank
- wr_key  in  1  raw push-button, active-low, asynchronous to clk
- mode  in  1  0 = load, 1 = run
- dir  in  1  0 = scroll left (base+1), 1 = scroll right (base-1)
- pause  in  1  1 = freeze scrolling while in run
- c0..c5  out  2 each  window characters, c0 = leftmost
- wr_ptr  out  clog2(MSG_LEN)  next message slot to be written
- running  out  1  high in state RUN only
- tick  out  1  one-cycle pulse on each scroll step

Behaviour:
- Reset is asynchronous on aclr low:
  - state=LOAD, wr_ptr=0, base=0, prescaler=0, tick=0.
  - All message entries are 11 (blank), so c0..c5=11.
  - Synchroniser flops are preset to 1 (key released).
- Key input:
  - wr_key passes through a 2-flop synchroniser.
  - A press event is a one-cycle pulse on the synchronised 1->0 transition. It appears 3 clk edges after wr_key falls.
  - Holding the key gives exactly one event. Bounce filtering is not required.
- State LOAD:
  - On a press event: mem[wr_ptr] <= code_in, and wr_ptr <= (wr_ptr+1) mod MSG_LEN.
  - A write after slot MSG_LEN-1 wraps to 0 and overwrites.
  - base stays 0, so the outputs show mem[0..5] live, including newly written entries on the following cycle.
  - mode=1 -> RUN; prescaler cleared on entry.
- State RUN:
  - The prescaler counts 0..TICK-1.
  - In the cycle where prescaler==TICK-1: tick=1, prescaler <= 0, and base <= base+1 (dir=0) or base-1 (dir=1), modulo MSG_LEN. base wraps MSG_LEN-1->0 and 0->MSG_LEN-1.
  - The first step occurs TICK cycles after entering RUN.
  - dir is sampled only at the step cycle.
  - Press events are ignored.
- State HOLD:
  - Entered from RUN when pause=1; prescaler and base are frozen and tick=0.
  - pause=0 -> RUN, resuming from the frozen prescaler value (no restart).
- Transitions from RUN or HOLD:
  - mode=0 -> LOAD with base <= 0, wr_ptr <= 0, prescaler <= 0. Message contents are retained.
  - mode=0 has priority over pause.
  - If a step cycle coincides with pause=1 or mode=0 in RUN, the step (tick, base update) still occurs on that edge. The state change takes the same edge, except that mode=0 forces base to 0.
- Output mapping: ck = mem[(base+k) mod MSG_LEN] for k=0..5.
  - Outputs are combinational from registered base/mem, so they change on the edge following the tick pulse.
  - The modulo is done with a compare-and-subtract, not a divider.
- Widths: base, wr_ptr and the index use clog2(MSG_LEN) bits; the prescaler uses clog2(TICK) bits.
- running = (state==RUN); it is registered with the state.

Decomposition:
- Shared package:
  - Letter code constants CODE_D=2'b00, CODE_E=2'b01, CODE_ONE=2'b10, CODE_BLANK=2'b11.
  - State encoding LOAD=2'd0, RUN=2'd1, HOLD=2'd2.
  - The clog2 function.
- One sub-module: key_press_detect.
  - Contents: 2-flop synchroniser plus falling-edge pulse.
  - Ports: clk, aclr, key_n, press.
  - It is reused by other key-driven blocks.
- The prescaler, FSM, message memory and window mux stay in the top module.

Test Plan (TICK=4, MSG_LEN=8):
- Reset check: assert aclr low mid-run -> c0..c5=11, wr_ptr=0, running=0, tick=0 immediately, without waiting for a clock edge.
- Load sequence: in LOAD, press 8 times with codes 00,01,10,11,00,01,10,11 -> wr_ptr steps 1..7 then 0; c0..c5 = 00,01,10,11,00,01. A held key (low for 20 cycles) writes once only.
- Run left: mode=1, dir=0 -> tick pulses at cycles 4,8,12,...
  - After the 1st tick, c0..c5 = 01,10,11,00,01,10.
  - After 8 ticks the window returns to its initial value (wrap).
- Run right from base=0: dir=1 -> after the 1st tick c0 = mem[7] = 11, and c1..c5 = 00,01,10,11,00.
- Pause: pause=1 with prescaler=2 for 10 cycles -> no tick and outputs stable. Release -> next tick exactly 2 cycles later.
- Boundary edge: mode=0 and pause=1 asserted on the step cycle -> tick=1 that cycle. State -> LOAD, base=0, and c0..c5 show mem[0..5]. Presses in RUN/HOLD do not change the memory.
